// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding and a
// constant-foldable ceiling-log2 used to size counters.
package adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Returns ceil(log2(value)); callers clamp to a minimum width of 1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of fulladder cells;
// serial_adder uses it for one digit per clock.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             c_in,
   output logic [DIGIT-1:0] sum,
   output logic             c_out
);

   logic [DIGIT:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      fulladder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .c_in (carry[i]),
         .sum  (sum[i]),
         .c_out(carry[i+1])
      );
   end

   assign c_out = carry[DIGIT];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder; the building block chained by digit_adder.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: {c_out,sum} = a + b + c_in, computed DIGIT bits per clock
// through a single registered carry, with valid/ready handshakes on both sides.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

   if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT, with 1 <= DIGIT <= WIDTH");
   end

   state_t                 state;
   logic [WIDTH-1:0]       a_sh;
   logic [WIDTH-1:0]       b_sh;
   logic                   carry;
   logic [CW-1:0]          cnt;
   logic [DIGIT-1:0]       d_sum;
   logic                   d_cout;
   logic [WIDTH+DIGIT-1:0] sum_cat;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .c_in (carry),
      .sum  (d_sum),
      .c_out(d_cout)
   );

   // New digits enter at the MSB end so that after N shifts the LSB digit lands at bit 0.
   assign sum_cat  = {d_sum, sum};
   assign in_ready = (state == S_IDLE) && !rst;
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= d_cout;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  c_out     <= d_cout;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across several WIDTH/DIGIT configurations;
// expected sums come from a behavioural a+b+c_in model.
module tb_serial_adder;

   localparam int NI = 6;
   localparam int WS [NI] = '{8, 8, 8, 4, 4, 4};
   localparam int DS [NI] = '{1, 4, 8, 1, 2, 4};

   typedef struct {
      logic [7:0] sum;
      logic       cout;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst       [NI];
   logic       in_valid  [NI];
   logic       in_ready  [NI];
   logic [7:0] a_v       [NI];
   logic [7:0] b_v       [NI];
   logic       c_in      [NI];
   logic       out_valid [NI];
   logic       out_ready [NI];
   logic [7:0] sum_v     [NI];
   logic       c_out     [NI];
   logic       busy      [NI];

   exp_t expQ [$];
   int   checkCount = 0;
   int   passCount  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [WS[g]-1:0] s;
      serial_adder #(.WIDTH(WS[g]), .DIGIT(DS[g])) dut (
         .clk      (clk),
         .rst      (rst[g]),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .a        (a_v[g][WS[g]-1:0]),
         .b        (b_v[g][WS[g]-1:0]),
         .c_in     (c_in[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .sum      (s),
         .c_out    (c_out[g]),
         .busy     (busy[g])
      );
      assign sum_v[g] = 8'(s);
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      else
         passCount++;
   endtask

   // Drives one operation into instance idx, holds the result for 'stall' cycles, then consumes it.
   task automatic applyStimulus(input int idx, input logic [7:0] av, input logic [7:0] bv,
                                input logic ci, input int stall, input bit toggleIn);
      exp_t       e;
      exp_t       got;
      int         lat;
      int         n;
      logic [7:0] mask;
      logic [8:0] full;
      n    = WS[idx] / DS[idx];
      mask = 8'((1 << WS[idx]) - 1);
      full = {1'b0, av & mask} + {1'b0, bv & mask} + 9'(ci);
      e.sum  = full[7:0] & mask;
      e.cout = full[WS[idx]];
      expQ.push_back(e);

      a_v[idx]       = av;
      b_v[idx]       = bv;
      c_in[idx]      = ci;
      in_valid[idx]  = 1'b1;
      out_ready[idx] = (stall == 0);
      checkOutput("in_ready_idle", 32'(in_ready[idx]), 32'd1);
      @(posedge clk); #1;
      in_valid[idx] = 1'b0;
      a_v[idx]      = ~av;
      b_v[idx]      = 8'($urandom);
      c_in[idx]     = ~ci;

      lat = 0;
      while (!out_valid[idx] && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(n));

      for (int i = 0; i < stall; i++) begin
         if (toggleIn) begin
            in_valid[idx] = i[0];
            a_v[idx]      = 8'($urandom);
            b_v[idx]      = 8'($urandom);
         end
         checkOutput("hold_in_ready", 32'(in_ready[idx]), 32'd0);
         checkOutput("hold_busy", 32'(busy[idx]), 32'd1);
         checkOutput("hold_valid", 32'(out_valid[idx]), 32'd1);
         checkOutput("hold_sum", 32'(sum_v[idx]), 32'(e.sum));
         checkOutput("hold_cout", 32'(c_out[idx]), 32'(e.cout));
         @(posedge clk); #1;
      end

      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b1;
      got = expQ.pop_front();
      checkOutput("out_valid", 32'(out_valid[idx]), 32'd1);
      checkOutput("sum", 32'(sum_v[idx]), 32'(got.sum));
      checkOutput("c_out", 32'(c_out[idx]), 32'(got.cout));
      @(posedge clk); #1;
      out_ready[idx] = 1'b0;
      checkOutput("valid_drop", 32'(out_valid[idx]), 32'd0);
      checkOutput("in_ready_back", 32'(in_ready[idx]), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst[i]       = 1'b1;
         in_valid[i]  = 1'b0;
         a_v[i]       = 8'h00;
         b_v[i]       = 8'h00;
         c_in[i]      = 1'b0;
         out_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         checkOutput("rst_in_ready", 32'(in_ready[i]), 32'd0);
         checkOutput("rst_out_valid", 32'(out_valid[i]), 32'd0);
         checkOutput("rst_sum", 32'(sum_v[i]), 32'd0);
         checkOutput("rst_c_out", 32'(c_out[i]), 32'd0);
         checkOutput("rst_busy", 32'(busy[i]), 32'd0);
         rst[i] = 1'b0;
      end
      @(posedge clk); #1;

      $display("[TB] basic carry ripple and back-to-back ops");
      applyStimulus(0, 8'hFF, 8'h01, 1'b0, 0, 1'b0);
      applyStimulus(0, 8'h5A, 8'hA5, 1'b1, 0, 1'b0);
      applyStimulus(0, 8'h12, 8'h34, 1'b0, 0, 1'b0);

      $display("[TB] backpressure with in_valid toggling in DONE");
      applyStimulus(0, 8'h77, 8'h88, 1'b1, 5, 1'b1);
      applyStimulus(0, 8'h01, 8'h02, 1'b0, 0, 1'b0);

      $display("[TB] reset mid-run");
      a_v[0]       = 8'h33;
      b_v[0]       = 8'h44;
      c_in[0]      = 1'b0;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      checkOutput("run_busy", 32'(busy[0]), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      #1;
      checkOutput("after_rst_in_ready", 32'(in_ready[0]), 32'd1);
      checkOutput("after_rst_busy", 32'(busy[0]), 32'd0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("aborted_no_valid", 32'(out_valid[0]), 32'd0);
         @(posedge clk); #1;
      end

      $display("[TB] reset wins over in_valid");
      rst[0]      = 1'b1;
      in_valid[0] = 1'b1;
      a_v[0]      = 8'hAA;
      b_v[0]      = 8'h55;
      #1;
      checkOutput("rst_gates_in_ready", 32'(in_ready[0]), 32'd0);
      @(posedge clk); #1;
      rst[0]      = 1'b0;
      in_valid[0] = 1'b0;
      #1;
      checkOutput("rst_no_capture", 32'(busy[0]), 32'd0);
      @(posedge clk); #1;
      applyStimulus(0, 8'h80, 8'h80, 1'b0, 1, 1'b0);

      $display("[TB] wider digits");
      applyStimulus(1, 8'h0F, 8'h01, 1'b0, 0, 1'b0);
      applyStimulus(2, 8'hFF, 8'hFF, 1'b1, 2, 1'b1);

      $display("[TB] exhaustive WIDTH=4 sweep");
      for (int idx = 3; idx < NI; idx++)
         for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
               for (int ci = 0; ci < 2; ci++)
                  applyStimulus(idx, 8'(av), 8'(bv), ci[0], int'($urandom_range(0, 2)), 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
